// File: rtl/serial_paralelo.sv
// ---------------------------------------------------------------------------
// serial_paralelo
//   Serial-to-parallel receiver with comma-based byte alignment.
//   The incoming bit stream (MSB of each byte first) is searched bit by bit
//   for the COMMA byte. Once NUM_COMMA consecutive byte-aligned commas have
//   been seen, the link goes active and every aligned non-comma byte is
//   presented on data_out with a one-cycle valid_out strobe.
//
// Parameters
//   COMMA      idle/sync byte sent by the transmitter when it has no data
//   NUM_COMMA  consecutive aligned commas required to go active (1..7)
//
// Ports
//   clk_32f    input   single clock, all logic on its rising edge
//   reset_L    input   synchronous active-low reset
//   data_in    input   serial bit stream, MSB first
//   data_out   output  [7:0] last recovered data byte, registered
//   valid_out  output  one-cycle strobe: data_out holds a new data byte
//   active     output  link aligned and passing data, registered
//
// Configuration
//   SP_RAW_OUT_EN  when defined, data_out also loads comma bytes at every
//                  active byte boundary (valid_out still stays low for them).
//                  When undefined, data_out holds the last data byte.
// ---------------------------------------------------------------------------
module serial_paralelo #(
  parameter logic [7:0] COMMA     = 8'hBC,
  parameter int         NUM_COMMA = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [2:0] NUM_COMMA_C = 3'(NUM_COMMA);

  state_t     state;
  logic [7:0] sr;
  logic [2:0] bit_cnt;
  logic [2:0] comma_cnt;

  // The byte as it will look once the bit currently on data_in is shifted in.
  logic [7:0] next_byte;
  logic       next_is_comma;
  logic       boundary;

  assign next_byte     = {sr[6:0], data_in};
  assign next_is_comma = (next_byte == COMMA);
  // Counter value 7 marks the cycle in which the LSB of a byte is sampled.
  assign boundary      = (bit_cnt == 3'd7);

  // NOTE: all state lives in one clocked block and uses non-blocking
  // assignments, so every decision below reads the values from before this
  // edge regardless of statement order.
  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      state     <= HUNT;
      sr        <= 8'h00;
      bit_cnt   <= 3'd0;
      comma_cnt <= 3'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      sr        <= next_byte;
      valid_out <= 1'b0;

      unique case (state)
        HUNT: begin
          // Bit-level search: any bit position may start a comma.
          if (next_is_comma) begin
            bit_cnt   <= 3'd0;
            comma_cnt <= 3'd1;
            if (NUM_COMMA_C == 3'd1) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else begin
              state <= ALIGN;
            end
          end
        end

        ALIGN: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (next_is_comma) begin
              comma_cnt <= comma_cnt + 3'd1;
              if (comma_cnt + 3'd1 == NUM_COMMA_C) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              // Alignment broken: fall back to searching on every bit.
              comma_cnt <= 3'd0;
              state     <= HUNT;
            end
          end
        end

        ACTIVE: begin
          // No loss-of-sync exit; only reset leaves this state.
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (!next_is_comma) begin
              data_out  <= next_byte;
              valid_out <= 1'b1;
            end else begin
`ifdef SP_RAW_OUT_EN
              data_out <= next_byte;
`else
              data_out <= data_out;
`endif
            end
          end
        end

        default: begin
          state <= HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_paralelo.sv
// ---------------------------------------------------------------------------
// tb_serial_paralelo
//   Directed bench for serial_paralelo. Stimulus pushes every data byte it
//   expects to see on the parallel side into a queue; an independent monitor
//   pops and compares whenever valid_out is high. Status outputs (active,
//   data_out during commas, reset values) are checked inline.
// ---------------------------------------------------------------------------
module tb_serial_paralelo;

  localparam logic [7:0] COMMA = 8'hBC;

  logic       clk_32f;
  logic       reset_L;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int         tests;
  int         fails;
  logic [7:0] exp_q[$];

  serial_paralelo #(
    .COMMA    (COMMA),
    .NUM_COMMA(4)
  ) dut (
    .clk_32f  (clk_32f),
    .reset_L  (reset_L),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  task automatic check(input string name, input logic [7:0] actual,
                       input logic [7:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Inputs change on the falling edge; the DUT samples on the rising edge.
  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_data(input logic [7:0] b);
    exp_q.push_back(b);
    send_byte(b);
  endtask

  // Wait for the edge that samples the last driven bit, then look just after.
  task automatic after_edge();
    @(posedge clk_32f);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    reset_L = 1'b0;
    data_in = 1'b0;
    repeat (3) @(negedge clk_32f);
    reset_L = 1'b1;
  endtask

  // Scoreboard monitor: every valid_out strobe must match the queue head.
  always @(negedge clk_32f) begin
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got %h, expected no strobe", data_out);
      end else begin
        check("scoreboard_byte", data_out, exp_q.pop_front());
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests   = 0;
    fails   = 0;
    reset_L = 1'b0;
    data_in = 1'b0;

    // Reset held 3 cycles, then 4 commas and five data bytes.
    repeat (3) @(negedge clk_32f);
    after_edge();
    check("reset_data_out", data_out, 8'h00);
    check("reset_valid", {7'd0, valid_out}, 8'd0);
    check("reset_active", {7'd0, active}, 8'd0);
    @(negedge clk_32f);
    reset_L = 1'b1;
    repeat (3) send_byte(COMMA);
    after_edge();
    check("t1_active_after_3bc", {7'd0, active}, 8'd0);
    send_byte(COMMA);
    after_edge();
    check("t1_active_after_4bc", {7'd0, active}, 8'd1);
    send_data(8'hFF);
    send_data(8'hFF);
    send_data(8'hEE);
    send_data(8'hEE);
    send_data(8'hEE);
    send_byte(COMMA);

    // Three stray bits before the commas: alignment must still be found.
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (4) send_byte(COMMA);
    send_data(8'h5A);
    after_edge();
    check("t2_active", {7'd0, active}, 8'd1);
    send_byte(COMMA);

    // A non-comma inside ALIGN drops back to HUNT with no output.
    do_reset();
    send_byte(COMMA);
    send_byte(COMMA);
    send_byte(8'h12);
    after_edge();
    check("t3_active_after_12", {7'd0, active}, 8'd0);
    repeat (4) send_byte(COMMA);
    send_data(8'h34);
    after_edge();
    check("t3_active", {7'd0, active}, 8'd1);

    // Commas between data bytes on an active link.
    send_data(8'hA1);
    send_byte(COMMA);
    send_byte(COMMA);
    after_edge();
`ifdef SP_RAW_OUT_EN
    check("t4_data_during_comma", data_out, 8'hBC);
`else
    check("t4_data_during_comma", data_out, 8'hA1);
`endif
    check("t4_valid_during_comma", {7'd0, valid_out}, 8'd0);
    send_data(8'hC3);
    send_byte(COMMA);

    // One-cycle reset in the middle of a data byte while active.
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    @(negedge clk_32f);
    reset_L = 1'b0;
    after_edge();
    check("t5_reset_data_out", data_out, 8'h00);
    check("t5_reset_valid", {7'd0, valid_out}, 8'd0);
    check("t5_reset_active", {7'd0, active}, 8'd0);
    @(negedge clk_32f);
    reset_L = 1'b1;
    data_in = 1'b0;
    repeat (3) send_byte(COMMA);
    after_edge();
    check("t5_active_after_3bc", {7'd0, active}, 8'd0);
    send_byte(COMMA);
    after_edge();
    check("t5_active_after_4bc", {7'd0, active}, 8'd1);
    send_data(8'h77);
    repeat (2) send_byte(COMMA);

    // Every expected byte must have been consumed by the monitor.
    check("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
